// File: rtl/arm_alu_pkg.sv
// Shared definitions for the pipelined ARM data-processing ALU: opcodes, NZCV bit
// positions and small flag helpers.
package arm_alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Compare/test ops: always set flags, never write back a result.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  function automatic logic calc_overflow(input logic a_sign, input logic b_sign,
                                         input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/arm_alu_core.sv
// Combinational ARM data-processing datapath: one shared adder for all arithmetic
// ops plus the logical unit, producing the result and its NZCV flags.
module arm_alu_core
  import arm_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       op_sel,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             shift_carry,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv
);

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_res;
  logic             is_arith;

  // Subtraction is a + ~b + cin, so the carry-out is directly NOT borrow.
  always_comb begin
    add_a     = op1;
    add_b     = op2;
    add_cin   = 1'b0;
    is_arith  = 1'b1;
    logic_res = '0;
    unique case (op_sel)
      OP_ADD, OP_CMN: ;
      OP_ADC: add_cin = c_in;
      OP_SUB, OP_CMP: begin
        add_b   = ~op2;
        add_cin = 1'b1;
      end
      OP_SBC: begin
        add_b   = ~op2;
        add_cin = c_in;
      end
      OP_RSB: begin
        add_a   = op2;
        add_b   = ~op1;
        add_cin = 1'b1;
      end
      OP_RSC: begin
        add_a   = op2;
        add_b   = ~op1;
        add_cin = c_in;
      end
      OP_AND, OP_TST: begin
        is_arith  = 1'b0;
        logic_res = op1 & op2;
      end
      OP_EOR, OP_TEQ: begin
        is_arith  = 1'b0;
        logic_res = op1 ^ op2;
      end
      OP_ORR: begin
        is_arith  = 1'b0;
        logic_res = op1 | op2;
      end
      OP_MOV: begin
        is_arith  = 1'b0;
        logic_res = op2;
      end
      OP_BIC: begin
        is_arith  = 1'b0;
        logic_res = op1 & ~op2;
      end
      OP_MVN: begin
        is_arith  = 1'b0;
        logic_res = ~op2;
      end
      default: ;
    endcase
  end

  always_comb begin
    sum            = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    result         = is_arith ? sum[WIDTH-1:0] : logic_res;
    nzcv           = '0;
    nzcv[FLAG_N]   = result[WIDTH-1];
    nzcv[FLAG_Z]   = (result == '0);
    nzcv[FLAG_C]   = is_arith ? sum[WIDTH] : shift_carry;
    nzcv[FLAG_V]   = is_arith ? calc_overflow(add_a[WIDTH-1], add_b[WIDTH-1], sum[WIDTH-1])
                              : v_in;
  end

endmodule

// File: rtl/arm_alu_pipe.sv
// Registered ARM ALU stage: valid/ready handshake, one-entry result register and the
// architectural NZCV register with S-bit and MSR-style updates.
module arm_alu_pipe
  import arm_alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_sel,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             shift_carry,
  input  logic             set_flags,
  input  logic             flags_we,
  input  logic [3:0]       flags_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic [3:0]       flags
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_we_q, result_we_d;
  logic [3:0]       flags_q, flags_d;
  logic             accept;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_nzcv;

  arm_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op1        (op1),
    .op2        (op2),
    .op_sel     (op_sel),
    .c_in       (flags_q[FLAG_C]),
    .v_in       (flags_q[FLAG_V]),
    .shift_carry(shift_carry),
    .result     (core_result),
    .nzcv       (core_nzcv)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_we_d = result_we_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_result;
      result_we_d = !is_test_op(op_sel);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // A direct flag write beats a same-edge flag-setting op.
  always_comb begin
    flags_d = flags_q;
    if (flags_we) begin
      flags_d = flags_wdata;
    end else if (accept && (set_flags || is_test_op(op_sel))) begin
      flags_d = core_nzcv;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_we_q <= 1'b0;
      flags_q     <= FLAGS_RST;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_we_q <= result_we_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_we = result_we_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_arm_alu_pipe.sv
// Directed and randomized checks of arm_alu_pipe (WIDTH=32 and WIDTH=8) against an
// arithmetic reference model of the ARM data-processing rules.
module tb_arm_alu_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op_sel, flags_wdata, flags;
  logic [31:0] op1, op2, result;
  logic        shift_carry, set_flags, flags_we, result_we;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0]  op_sel8, flags8;
  logic [7:0]  op1_8, op2_8, result8;
  logic        set_flags8, result_we8;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state for the 32-bit instance.
  logic            m_valid;
  longint unsigned m_result;
  logic            m_we;
  logic [3:0]      m_flags;

  always #5 clk = ~clk;

  arm_alu_pipe #(.WIDTH(32), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .op1(op1), .op2(op2), .shift_carry(shift_carry),
    .set_flags(set_flags), .flags_we(flags_we), .flags_wdata(flags_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_we(result_we), .flags(flags)
  );

  arm_alu_pipe #(.WIDTH(8), .FLAGS_RST(4'b0000)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op_sel(op_sel8), .op1(op1_8), .op2(op2_8), .shift_carry(1'b0),
    .set_flags(set_flags8), .flags_we(1'b0), .flags_wdata(4'b0000),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .result_we(result_we8), .flags(flags8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_test(input logic [3:0] op);
    return op inside {4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  function automatic longint sx(input longint unsigned x, input int w);
    if (((x >> (w - 1)) & 1) != 0) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  // Result and NZCV from the architectural definitions, in plain integer arithmetic.
  function automatic void ref_op(input int w, input logic [3:0] op,
                                 input longint unsigned a, input longint unsigned b,
                                 input logic [3:0] fl, input logic sc,
                                 output longint unsigned res, output logic [3:0] nz);
    longint unsigned mask = (longint'(1) << w) - 1;
    longint lo = -(longint'(1) << (w - 1));
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint unsigned x = a, y = b, u;
    longint t;
    longint unsigned k;
    logic c = sc, v = fl[0];
    logic is_add = 0, is_sub = 0;
    case (op)
      4'd0, 4'd8:  res = a & b;
      4'd1, 4'd9:  res = a ^ b;
      4'd12:       res = a | b;
      4'd13:       res = b;
      4'd14:       res = a & ~b & mask;
      4'd15:       res = ~b & mask;
      4'd4, 4'd11: begin is_add = 1; k = 0; end
      4'd5:        begin is_add = 1; k = longint'(fl[1]); end
      4'd2, 4'd10: begin is_sub = 1; k = 0; end
      4'd6:        begin is_sub = 1; k = longint'(!fl[1]); end
      4'd3:        begin is_sub = 1; k = 0; x = b; y = a; end
      default:     begin is_sub = 1; k = longint'(!fl[1]); x = b; y = a; end
    endcase
    if (is_add) begin
      u   = x + y + k;
      res = u & mask;
      c   = (u >> w) != 0;
      t   = sx(x, w) + sx(y, w) + longint'(k);
      v   = (t < lo) || (t > hi);
    end else if (is_sub) begin
      res = (x - y - k) & mask;
      c   = x >= (y + k);
      t   = sx(x, w) - sx(y, w) - longint'(k);
      v   = (t < lo) || (t > hi);
    end
    nz = {res[w-1], res == 0, c, v};
  endfunction

  // One clock of the 32-bit DUT: drive, predict, clock, compare.
  task automatic cycle(input logic iv, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic sc,
                       input logic ordy, input logic fwe, input logic [3:0] fwd);
    longint unsigned r;
    logic [3:0] nz;
    logic acc;
    in_valid = iv; op_sel = op; op1 = a; op2 = b; set_flags = s; shift_carry = sc;
    out_ready = ordy; flags_we = fwe; flags_wdata = fwd;
    #1;
    acc = iv && (!m_valid || ordy);
    chk("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
    ref_op(32, op, 64'(a), 64'(b), m_flags, sc, r, nz);
    if (fwe) m_flags = fwd;
    else if (acc && (s || is_test(op))) m_flags = nz;
    if (acc) begin
      m_result = r;
      m_we     = !is_test(op);
      m_valid  = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flags_we = 1'b0;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("result", 64'(result), m_result);
    chk("result_we", 64'(result_we), 64'(m_we));
    chk("flags", 64'(flags), 64'(m_flags));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    longint unsigned r8;
    logic [3:0] nz8;
    reset_n = 1'b0;
    in_valid = 0; op_sel = 0; op1 = 0; op2 = 0; shift_carry = 0; set_flags = 0;
    flags_we = 0; flags_wdata = 0; out_ready = 1;
    in_valid8 = 0; op_sel8 = 0; op1_8 = 0; op2_8 = 0; set_flags8 = 0; out_ready8 = 1;
    m_valid = 0; m_result = 0; m_we = 0; m_flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_result_we", 64'(result_we), 64'(0));
    chk("rst_flags", 64'(flags), 64'(4'b0000));
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // ADDS signed overflow
    cycle(1, 4'd4, 32'h7FFF_FFFF, 32'h1, 1, 0, 1, 0, 4'h0);
    chk("adds_ovf_res", 64'(result), 64'h8000_0000);
    chk("adds_ovf_nzcv", 64'(flags), 64'(4'b1001));
    chk("adds_ovf_we", 64'(result_we), 64'(1));

    // CMP then non-flag-setting SUB
    cycle(1, 4'd10, 32'd5, 32'd5, 0, 0, 1, 0, 4'h0);
    chk("cmp_nzcv", 64'(flags), 64'(4'b0110));
    chk("cmp_we", 64'(result_we), 64'(0));
    cycle(1, 4'd2, 32'd3, 32'd5, 0, 0, 1, 0, 4'h0);
    chk("sub_res", 64'(result), 64'hFFFF_FFFE);
    chk("sub_flags_held", 64'(flags), 64'(4'b0110));

    // Carry chain through the flags register, no bubble
    cycle(1, 4'd4, 32'hFFFF_FFFF, 32'h1, 1, 0, 1, 0, 4'h0);
    chk("adds_c_res", 64'(result), 64'h0);
    chk("adds_c_flag", 64'(flags[1]), 64'(1));
    cycle(1, 4'd5, 32'h0, 32'h0, 0, 0, 1, 0, 4'h0);
    chk("adc_res", 64'(result), 64'h1);
    cycle(0, 4'd0, 32'h0, 32'h0, 0, 0, 1, 1, 4'b0000);
    cycle(1, 4'd6, 32'd5, 32'd2, 0, 0, 1, 0, 4'h0);
    chk("sbc_res", 64'(result), 64'h2);

    // Back-pressure
    for (int i = 0; i < 3; i++) begin
      cycle(1, 4'd4, 32'd10, 32'd20, 0, 0, 0, 0, 4'h0);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_res", 64'(result), 64'h2);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 4'd4, 32'(10 + i), 32'd20, 0, 0, 1, 0, 4'h0);
      chk("stream_res", 64'(result), 64'(30 + i));
      chk("stream_valid", 64'(out_valid), 64'(1));
    end
    cycle(0, 4'd4, 32'd0, 32'd0, 0, 0, 1, 0, 4'h0);
    chk("drain_valid", 64'(out_valid), 64'(0));
    chk("drain_res_hold", 64'(result), 64'd32);

    // flags_we beats a same-edge ANDS
    cycle(1, 4'd0, 32'hF0, 32'h0F, 1, 1, 1, 1, 4'b0101);
    chk("prio_flags", 64'(flags), 64'(4'b0101));
    chk("prio_res", 64'(result), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom), pick(), pick(),
            1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, 4'($urandom));
    end

    // Reset in the middle of a stall
    cycle(1, 4'd4, 32'd1, 32'd2, 0, 0, 1, 0, 4'h0);
    cycle(1, 4'd4, 32'd3, 32'd4, 0, 0, 0, 1, 4'b1111);
    chk("pre_rst_flags", 64'(flags), 64'(4'b1111));
    in_valid = 1'b1;
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_flags", 64'(flags), 64'(4'b0000));
    chk("mid_rst_result", 64'(result), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_valid = 0; m_result = 0; m_we = 0; m_flags = 4'b0000;
    cycle(1, 4'd13, 32'h0, 32'h1234_5678, 1, 0, 1, 0, 4'h0);
    chk("post_rst_mov", 64'(result), 64'h1234_5678);

    // WIDTH=8 instance
    in_valid8 = 1; op_sel8 = 4'd4; op1_8 = 8'h80; op2_8 = 8'h80; set_flags8 = 1;
    #1;
    chk("w8_in_ready", 64'(in_ready8), 64'(1));
    @(posedge clk);
    #1;
    chk("w8_adds_res", 64'(result8), 64'h00);
    chk("w8_adds_nzcv", 64'(flags8), 64'(4'b0111));
    chk("w8_out_valid", 64'(out_valid8), 64'(1));
    ref_op(8, 4'd2, 64'h00, 64'h01, flags8, 1'b0, r8, nz8);
    op_sel8 = 4'd2; op1_8 = 8'h00; op2_8 = 8'h01;
    @(posedge clk);
    #1;
    in_valid8 = 0;
    chk("w8_subs_res", 64'(result8), r8);
    chk("w8_subs_nzcv", 64'(flags8), 64'(nz8));
    chk("w8_subs_nzcv_abs", 64'(flags8), 64'(4'b1000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
